// File: rtl/mem_pkg.sv
// Shared definitions for clients of the word-addressed data memory.
package mem_pkg;
    localparam int DEPTH  = 1024;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_WRITE = 2'd1;
    localparam state_t S_READ  = 2'd2;
    localparam state_t S_RESP  = 2'd3;
endpackage

// File: rtl/data_mem_master.sv
// Request/response master for a negedge-registered data memory: single-word
// stores and burst loads with a stallable, one-beat-at-a-time response path.
module data_mem_master #(
    parameter int DEPTH = mem_pkg::DEPTH,
    parameter int LEN_W = mem_pkg::LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [LEN_W-1:0] req_len,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_last,
    output logic             err,
    output logic             mem_write,
    output logic             mem_read,
    output logic [31:0]      mem_daddress,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout
);
    import mem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_last_q, resp_last_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q, mem_read_d;
    logic [31:0]      din_q, din_d;
    logic             accept;
    logic             in_range;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign in_range  = req_addr < 32'(DEPTH);

    // Strobes are registered on entry to WRITE/READ so they are high for exactly that state's cycle.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        resp_valid_d = resp_valid_q;
        resp_last_d  = resp_last_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        din_d        = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (req_write) begin
                        addr_d      = req_addr[AW-1:0];
                        din_d       = req_wdata;
                        mem_write_d = 1'b1;
                        state_d     = S_WRITE;
                    end else begin
                        addr_d     = req_addr[AW-1:0];
                        beats_d    = req_len;
                        mem_read_d = 1'b1;
                        state_d    = S_READ;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                rdata_d      = mem_dout;
                resp_valid_d = 1'b1;
                resp_last_d  = (beats_q == '0);
                state_d      = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_last_d  = 1'b0;
                    if (beats_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        beats_d    = beats_q - LEN_W'(1);
                        addr_d     = addr_q + AW'(1);
                        mem_read_d = 1'b1;
                        state_d    = S_READ;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beats_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            din_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            din_q        <= din_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_last    = resp_last_q;
    assign resp_rdata   = rdata_q;
    assign err          = err_q;
    assign mem_write    = mem_write_q;
    assign mem_read     = mem_read_q;
    assign mem_daddress = 32'(addr_q);
    assign mem_din      = din_q;
endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master paired with a negedge-registered memory.
module tb_data_mem_master;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_len;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_last;
    logic        err;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_daddress;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int hs_cnt = 0;
    int rd0, wr0, hs0;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_addr [0:3];
    logic [31:0] exp_data [0:3];
    logic [31:0] held;

    data_mem_master #(.DEPTH(1024), .LEN_W(3)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_last(resp_last), .err(err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_daddress(mem_daddress),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // Memory model: preloaded while reset is high, registers on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[1]    <= 32'd1;
            mem[6]    <= 32'd6;
            mem[1022] <= 32'hA0A0_03FE;
            mem[1023] <= 32'hA0A0_03FF;
            mem[0]    <= 32'hA0A0_0000;
        end else begin
            if (mem_write) mem[mem_daddress[9:0]] <= mem_din;
            if (mem_read)  mem_dout <= mem[mem_daddress[9:0]];
        end
    end

    always @(negedge clock) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (resp_valid && resp_ready) hs_cnt++;
        checks++;
        assert (!(mem_write && mem_read) && (mem_daddress < 32'd1024)) else begin
            failures++;
            $error("FAIL strobe_addr_invariant obs wr=%0b rd=%0b addr=%0d exp exclusive and <1024",
                   mem_write, mem_read, mem_daddress);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_len = 3'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_daddress", mem_daddress, 32'd0);
        chk("rst_din", mem_din, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Single load of word 6
        rd0 = rd_cnt;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd6; req_len = 3'd0;
        tick();
        req_valid = 1'b0;
        chk("ld6_mem_read", 32'(mem_read), 32'd1);
        chk("ld6_addr", mem_daddress, 32'd6);
        chk("ld6_ready_busy", 32'(req_ready), 32'd0);
        chk("ld6_no_early_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("ld6_read_done", 32'(mem_read), 32'd0);
        chk("ld6_valid", 32'(resp_valid), 32'd1);
        chk("ld6_rdata", resp_rdata, 32'd6);
        chk("ld6_last", 32'(resp_last), 32'd1);
        tick();
        chk("ld6_valid_clear", 32'(resp_valid), 32'd0);
        chk("ld6_idle", 32'(req_ready), 32'd1);
        chk("ld6_read_cycles", 32'(rd_cnt - rd0), 32'd1);

        // Store then load back; a request during WRITE must be ignored
        wr0 = wr_cnt; hs0 = hs_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_mem_write", 32'(mem_write), 32'd1);
        chk("st_mem_read", 32'(mem_read), 32'd0);
        chk("st_din", mem_din, 32'hDEAD_BEEF);
        chk("st_addr", mem_daddress, 32'd5);
        req_addr = 32'd9; req_wdata = 32'h0000_0099;
        tick();
        req_valid = 1'b0;
        chk("st_write_done", 32'(mem_write), 32'd0);
        chk("st_din_zero", mem_din, 32'd0);
        chk("st_no_resp", 32'(resp_valid), 32'd0);
        tick();
        chk("st_write_cycles", 32'(wr_cnt - wr0), 32'd1);
        chk("st_no_handshake", 32'(hs_cnt - hs0), 32'd0);
        chk("st_ignored_word9", mem[9], 32'd0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5; req_len = 3'd0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ld5_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("ld5_last", 32'(resp_last), 32'd1);
        tick();

        // Wrapping burst with stalls on even beats
        exp_addr[0] = 32'd1022; exp_addr[1] = 32'd1023; exp_addr[2] = 32'd0; exp_addr[3] = 32'd1;
        exp_data[0] = 32'hA0A0_03FE; exp_data[1] = 32'hA0A0_03FF;
        exp_data[2] = 32'hA0A0_0000; exp_data[3] = 32'd1;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1022; req_len = 3'd3;
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("burst_rd%0d", b), 32'(mem_read), 32'd1);
            chk($sformatf("burst_addr%0d", b), mem_daddress, exp_addr[b]);
            chk($sformatf("burst_novalid%0d", b), 32'(resp_valid), 32'd0);
            resp_ready = 1'b0;
            tick();
            chk($sformatf("burst_valid%0d", b), 32'(resp_valid), 32'd1);
            chk($sformatf("burst_data%0d", b), resp_rdata, exp_data[b]);
            chk($sformatf("burst_last%0d", b), 32'(resp_last), (b == 3) ? 32'd1 : 32'd0);
            held = resp_rdata;
            if (b % 2 == 0) begin
                tick();
                chk($sformatf("burst_hold_valid%0d", b), 32'(resp_valid), 32'd1);
                chk($sformatf("burst_hold_data%0d", b), resp_rdata, exp_data[b]);
                chk($sformatf("burst_hold_nord%0d", b), 32'(mem_read), 32'd0);
            end
            resp_ready = 1'b1;
            tick();
        end
        chk("burst_end_valid", 32'(resp_valid), 32'd0);
        chk("burst_end_last", 32'(resp_last), 32'd0);
        chk("burst_end_ready", 32'(req_ready), 32'd1);

        // Out-of-range request
        rd0 = rd_cnt; wr0 = wr_cnt; hs0 = hs_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1024; req_len = 3'd0;
        tick();
        req_valid = 1'b0;
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_idle", 32'(req_ready), 32'd1);
        tick();
        chk("oor_err_pulse", 32'(err), 32'd0);
        tick();
        chk("oor_no_read", 32'(rd_cnt - rd0), 32'd0);
        chk("oor_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("oor_no_resp", 32'(hs_cnt - hs0), 32'd0);

        // Reset during beat 2 of an 8-beat burst
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1; req_len = 3'd7;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("rb_beat2_read", 32'(mem_read), 32'd1);
        chk("rb_beat2_addr", mem_daddress, 32'd3);
        reset = 1'b1;
        tick();
        rd0 = rd_cnt; hs0 = hs_cnt;
        chk("rb_read_clr", 32'(mem_read), 32'd0);
        chk("rb_valid_clr", 32'(resp_valid), 32'd0);
        chk("rb_rdata_clr", resp_rdata, 32'd0);
        chk("rb_addr_clr", mem_daddress, 32'd0);
        chk("rb_ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rb_ready_after", 32'(req_ready), 32'd1);
        repeat (4) tick();
        chk("rb_no_more_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("rb_no_resp", 32'(hs_cnt - hs0), 32'd0);
        chk("rb_valid_idle", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_master.md
DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL give the number of addressable 32-bit words in the attached data memory (power of 2).
REQ-002 Parameter LEN_W, default 3, SHALL give the width of the burst-length field.
REQ-003 clock  in  1  SHALL be the single clock; all block state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mark a valid client request.
REQ-006 req_ready  out  1  SHALL mark that the block accepts a request this cycle.
REQ-007 req_write  in  1  SHALL select a store (1) or a load (0).
REQ-008 req_addr  in  32  SHALL give the word address of the request.
REQ-009 req_wdata  in  32  SHALL give the store data.
REQ-010 req_len  in  LEN_W  SHALL give the load burst beats minus one; it is ignored for stores.
REQ-011 resp_valid  out  1  SHALL mark valid load data.
REQ-012 resp_ready  in  1  SHALL mark that the client accepts the response.
REQ-013 resp_rdata  out  32  SHALL carry the load data.
REQ-014 resp_last  out  1  SHALL mark the final beat of a burst.
REQ-015 err  out  1  SHALL pulse for one cycle when an out-of-range request is dropped.
REQ-016 mem_write, mem_read  out  1 each  SHALL be the memory strobes.
REQ-017 mem_daddress, mem_din  out  32 each  SHALL be the memory address and write data.
REQ-018 mem_dout  in  32  SHALL be the memory read data, which the memory registers on the falling clock edge.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, READ and RESP.
REQ-020 req_ready SHALL equal (state==IDLE && !reset) and SHALL be driven combinationally.
REQ-021 In IDLE, on req_valid&&req_ready with req_addr>=DEPTH, the block SHALL drop the request, pulse err the next cycle, and remain in IDLE.
REQ-022 In IDLE, on an accepted in-range store, the block SHALL register the address and data and enter WRITE.
REQ-023 In WRITE, the block SHALL hold mem_write=1 and mem_read=0 for exactly one cycle and then return to IDLE; a store produces no response.
REQ-024 In IDLE, on an accepted in-range load, the block SHALL register the address and set beats_left=req_len, then enter READ.
REQ-025 In READ, the block SHALL hold mem_read=1 for exactly one cycle, and on the edge leaving READ SHALL capture mem_dout into resp_rdata, set resp_valid=1, set resp_last=(beats_left==0), and enter RESP.
REQ-026 In RESP, mem_read and mem_write SHALL be 0.
REQ-027 In RESP, resp_valid, resp_rdata and resp_last SHALL be held stable until resp_ready=1.
REQ-028 On the RESP handshake with beats_left==0, the block SHALL clear resp_valid and resp_last and enter IDLE.
REQ-029 On the RESP handshake with beats_left>0, the block SHALL decrement beats_left, set address=(address+1) mod DEPTH, clear resp_valid, and enter READ.
REQ-030 Load latency SHALL be 1 cycle from the READ cycle to resp_valid, and a beat SHALL take at least 2 cycles.
REQ-031 A request presented while req_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-032 mem_daddress SHALL always be less than DEPTH, and mem_write and mem_read SHALL never be 1 in the same cycle.
REQ-033 mem_din SHALL be driven only in WRITE and SHALL be 0 otherwise.

Reset
REQ-034 While reset=1, on each clock edge the state SHALL become IDLE and beats_left, address, resp_valid, resp_rdata, resp_last, err, mem_write, mem_read, mem_daddress and mem_din SHALL become 0.
REQ-035 A reset asserted mid-burst or mid-write SHALL abandon the operation with no further strobes and no response.
REQ-036 req_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-037 Package mem_pkg SHALL hold DEPTH, the data width (32), LEN_W and the state enumeration, shared with other memory clients.
REQ-038 The block SHALL be a single module with no sub-module; the beat counter and address incrementer SHALL be implemented inline.

Verification
REQ-039 The bench SHALL pair the block with a negedge-registered memory model of DEPTH 1024, preloaded with word1=1 and word6=6.
REQ-040 Load addr=6, len=0, resp_ready=1: mem_read SHALL be high for 1 cycle, then resp_rdata=6 and resp_last=1 on the next cycle.
REQ-041 Store addr=5, data=0xDEADBEEF, then load addr=5: the block SHALL return 0xDEADBEEF, and the store SHALL produce exactly one mem_write cycle and no response.
REQ-042 Burst load addr=1022, len=3 with resp_ready toggling: the block SHALL access addresses 1022, 1023, 0 and 1 in order, with rdata held stable while stalled and resp_last on the 4th beat only.
REQ-043 Request addr=1024: err SHALL pulse for 1 cycle, with no memory strobes and no response.
REQ-044 Reset asserted during beat 2 of a len=7 burst: the block SHALL clear all outputs on the next edge, produce no further mem_read, and assert req_ready after release.
